// File: rtl/cpu_core_pkg.sv
// rtl/cpu_core_pkg.sv - opcode enumeration, phase constants and data width for the bit-serial core.
package cpu_core_pkg;

  localparam int         DATA_W      = 8;
  localparam logic [3:0] PHASE_FETCH = 4'd0;
  localparam logic [3:0] PHASE_LAST  = 4'd8;

  typedef enum logic [3:0] {
    OP_NOP   = 4'h0,
    OP_LDI   = 4'h1,
    OP_LDH   = 4'h2,
    OP_ADD   = 4'h3,
    OP_SUB   = 4'h4,
    OP_AND   = 4'h5,
    OP_OR    = 4'h6,
    OP_XOR   = 4'h7,
    OP_MOV   = 4'h8,
    OP_MOVA  = 4'h9,
    OP_JMP   = 4'hA,
    OP_JZ    = 4'hB,
    OP_JC    = 4'hC,
    OP_OUT   = 4'hD,
    OP_SHIFT = 4'hE,
    OP_HALT  = 4'hF
  } opcode_t;

  // Opcodes that stream ACC and Rn through the serial cell during phases 1-8.
  function automatic logic is_alu_op(input opcode_t op);
    return (op inside {OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR});
  endfunction

endpackage

// File: rtl/cpu_serial_alu.sv
// rtl/cpu_serial_alu.sv - 1-bit add/sub/and/or/xor cell with carry flop, LSB first.
module cpu_serial_alu
  import cpu_core_pkg::*;
(
  input  logic    clk,
  input  logic    i_rst,
  input  logic    i_en,
  input  logic    i_init,
  input  opcode_t i_op,
  input  logic    i_a,
  input  logic    i_b,
  output logic    o_res,
  output logic    o_cout
);

  logic r_carry;
  logic w_sub;
  logic w_b;
  logic w_cin;

  assign w_sub = (i_op == OP_SUB);
  assign w_b   = w_sub ? ~i_b : i_b;
  // The first bit of an operation ignores the stale flop: 0 for add, 1 for the +1 of subtract.
  assign w_cin = i_init ? w_sub : r_carry;

  always_comb begin
    o_res  = 1'b0;
    o_cout = 1'b0;
    case (i_op)
      OP_ADD, OP_SUB: begin
        o_res  = i_a ^ w_b ^ w_cin;
        o_cout = (i_a & w_b) | (i_a & w_cin) | (w_b & w_cin);
      end
      OP_AND:  o_res = i_a & i_b;
      OP_OR:   o_res = i_a | i_b;
      OP_XOR:  o_res = i_a ^ i_b;
      default: o_res = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (i_rst) begin
      r_carry <= 1'b0;
    end else if (i_en) begin
      r_carry <= o_cout;
    end
  end

endmodule

// File: rtl/cpu_core.sv
// rtl/cpu_core.sv - 9-cycle bit-serial 8-bit accumulator core; CPU_SHIFT_EN enables SHL/SHR on opcode E.
module cpu_core
  import cpu_core_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ena,
  input  logic [DATA_W-1:0] ui_in,
  input  logic [DATA_W-1:0] uio_in,
  output logic [DATA_W-1:0] uo_out,
  output logic [DATA_W-1:0] uio_out,
  output logic [DATA_W-1:0] uio_oe
);

  logic [DATA_W-1:0] r_pc;
  logic [DATA_W-1:0] r_ir;
  logic [DATA_W-1:0] r_acc;
  logic [DATA_W-1:0] r_outl;
  logic [DATA_W-1:0] r_reg [4];
  logic              r_z;
  logic              r_c;
  logic              r_halted;
  logic [3:0]        r_phase;

  opcode_t           w_opc;
  logic [1:0]        w_n;
  logic [3:0]        w_imm;
  logic              w_run;
  logic              w_exec;
  logic              w_last;
  logic              w_alu;
  logic              w_res;
  logic              w_cout;
  logic [DATA_W-1:0] w_rn;
  logic [DATA_W-1:0] w_alu_acc;
  logic              w_unused;

  assign w_opc     = opcode_t'(r_ir[7:4]);
  assign w_imm     = r_ir[3:0];
  assign w_n       = r_ir[1:0];
  assign w_run     = ena & ~r_halted;
  assign w_exec    = (r_phase != PHASE_FETCH);
  assign w_last    = (r_phase == PHASE_LAST);
  assign w_alu     = w_exec & is_alu_op(w_opc);
  assign w_rn      = r_reg[w_n];
  assign w_alu_acc = {w_res, r_acc[DATA_W-1:1]};
  assign w_unused  = ^uio_in;

  assign uo_out  = r_outl;
  assign uio_out = r_pc;
  assign uio_oe  = 8'hFF;

  cpu_serial_alu u_alu (
    .clk    (clk),
    .i_rst  (rst_n),
    .i_en   (w_run & w_alu),
    .i_init (r_phase == 4'd1),
    .i_op   (w_opc),
    .i_a    (r_acc[0]),
    .i_b    (w_rn[0]),
    .o_res  (w_res),
    .o_cout (w_cout)
  );

  always_ff @(posedge clk) begin
    if (rst_n) begin
      r_pc     <= '0;
      r_ir     <= '0;
      r_acc    <= '0;
      r_outl   <= '0;
      r_z      <= 1'b0;
      r_c      <= 1'b0;
      r_halted <= 1'b0;
      r_phase  <= PHASE_FETCH;
      for (int i = 0; i < 4; i++) r_reg[i] <= '0;
    end else if (w_run) begin
      if (!w_exec) begin
        r_ir    <= ui_in;
        r_pc    <= r_pc + 8'd1;
        r_phase <= 4'd1;
      end else begin
        r_phase <= w_last ? PHASE_FETCH : r_phase + 4'd1;
        if (w_alu) begin
          // After eight rotations ACC holds the result and Rn is back in place.
          r_acc      <= w_alu_acc;
          r_reg[w_n] <= {w_rn[0], w_rn[DATA_W-1:1]};
          if (w_last) begin
            r_z <= (w_alu_acc == '0);
            r_c <= w_cout;
          end
        end else if (w_last) begin
          case (w_opc)
            OP_LDI:  r_acc <= {4'h0, w_imm};
            OP_LDH:  r_acc <= {w_imm, r_acc[3:0]};
            OP_MOV:  r_reg[w_n] <= r_acc;
            OP_MOVA: r_acc <= w_rn;
            OP_JMP:  r_pc <= r_acc;
            OP_JZ:   if (r_z) r_pc <= r_acc;
            OP_JC:   if (r_c) r_pc <= r_acc;
            OP_OUT:  r_outl <= r_acc;
            OP_HALT: r_halted <= 1'b1;
`ifdef CPU_SHIFT_EN
            OP_SHIFT: begin
              if (r_ir[0]) begin
                r_acc <= {1'b0, r_acc[DATA_W-1:1]};
                r_c   <= r_acc[0];
                r_z   <= (r_acc[DATA_W-1:1] == '0);
              end else begin
                r_acc <= {r_acc[DATA_W-2:0], 1'b0};
                r_c   <= r_acc[DATA_W-1];
                r_z   <= (r_acc[DATA_W-2:0] == '0);
              end
            end
`endif
            default: ;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_cpu_core.sv
// tb/tb_cpu_core.sv - self-checking bench for cpu_core against an instruction-level reference model.
module tb_cpu_core;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       ena = 1'b0;
  logic [7:0] ui_in;
  logic [7:0] uio_in = 8'h5A;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  logic [7:0] mem [256];

  int total = 0;
  int bad   = 0;

  // Instruction-level model state.
  logic [7:0] m_pc, m_acc, m_out;
  logic [7:0] m_r [4];
  logic       m_z, m_c, m_halt;

  assign ui_in = mem[uio_out];

  always #5 clk = ~clk;

  cpu_core dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (ena),
    .ui_in   (ui_in),
    .uio_in  (uio_in),
    .uo_out  (uo_out),
    .uio_out (uio_out),
    .uio_oe  (uio_oe)
  );

  task automatic tick(input logic e);
    ena = e;
    uio_in = 8'($urandom);
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [7:0] p[$]);
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    for (int i = 0; i < p.size(); i++) mem[i] = p[i];
  endtask

  task automatic m_reset();
    m_pc = 0; m_acc = 0; m_out = 0; m_z = 0; m_c = 0; m_halt = 0;
    for (int i = 0; i < 4; i++) m_r[i] = 0;
  endtask

  task automatic do_reset(input logic e);
    rst_n = 1'b1;
    tick(e);
    tick(e);
    rst_n = 1'b0;
    ena = 1'b0;
    m_reset();
  endtask

  task automatic m_step();
    logic [7:0] ins, rn;
    logic [8:0] t;
    if (m_halt) return;
    ins = mem[m_pc];
    m_pc = m_pc + 8'd1;
    rn = m_r[ins[1:0]];
    case (ins[7:4])
      4'h1: m_acc = {4'h0, ins[3:0]};
      4'h2: m_acc[7:4] = ins[3:0];
      4'h3: begin t = {1'b0, m_acc} + {1'b0, rn}; m_acc = t[7:0]; m_c = t[8]; m_z = (m_acc == 0); end
      4'h4: begin t = {1'b0, m_acc} + {1'b0, ~rn} + 9'd1; m_acc = t[7:0]; m_c = t[8]; m_z = (m_acc == 0); end
      4'h5: begin m_acc = m_acc & rn; m_c = 0; m_z = (m_acc == 0); end
      4'h6: begin m_acc = m_acc | rn; m_c = 0; m_z = (m_acc == 0); end
      4'h7: begin m_acc = m_acc ^ rn; m_c = 0; m_z = (m_acc == 0); end
      4'h8: m_r[ins[1:0]] = m_acc;
      4'h9: m_acc = rn;
      4'hA: m_pc = m_acc;
      4'hB: if (m_z) m_pc = m_acc;
      4'hC: if (m_c) m_pc = m_acc;
      4'hD: m_out = m_acc;
`ifdef CPU_SHIFT_EN
      4'hE: begin
        if (ins[0]) begin m_c = m_acc[0]; m_acc = m_acc >> 1; end
        else begin m_c = m_acc[7]; m_acc = m_acc << 1; end
        m_z = (m_acc == 0);
      end
`endif
      4'hF: m_halt = 1;
      default: ;
    endcase
  endtask

  // Runs one instruction in the DUT (9 enabled cycles), optionally with random ena gaps.
  task automatic run_instr(input bit stall);
    int en_cnt = 0;
    logic e;
    while (en_cnt < 9) begin
      e = stall ? ($urandom_range(0, 3) != 0) : 1'b1;
      tick(e);
      if (e) en_cnt++;
    end
  endtask

  task automatic test_reset();
    load('{8'h15, 8'hD0});
    do_reset(1'b0);
    total++; if (uo_out !== 8'h00) begin bad++; $display("FAIL reset_uo_out got=%h exp=00", uo_out); end
    total++; if (uio_out !== 8'h00) begin bad++; $display("FAIL reset_pc got=%h exp=00", uio_out); end
    total++; if (uio_oe !== 8'hFF) begin bad++; $display("FAIL reset_oe got=%h exp=FF", uio_oe); end
    tick(1'b1);
    total++; if (uio_out !== 8'h01) begin bad++; $display("FAIL first_fetch_pc got=%h exp=01", uio_out); end
  endtask

  task automatic test_add();
    load('{8'h15, 8'h80, 8'h13, 8'h30, 8'hD0});
    do_reset(1'b1);
    for (int i = 0; i < 45; i++) tick(1'b1);
    total++; if (uo_out !== 8'h08) begin bad++; $display("FAIL add_out got=%h exp=08", uo_out); end
    total++; if ({dut.r_z, dut.r_c} !== 2'b00) begin bad++; $display("FAIL add_zc got=%b exp=00", {dut.r_z, dut.r_c}); end
  endtask

  task automatic test_carry_jz();
    load('{8'h1F, 8'h2F, 8'h81, 8'h11, 8'h31, 8'hD0, 8'hB0});
    do_reset(1'b1);
    for (int i = 0; i < 63; i++) tick(1'b1);
    total++; if (uo_out !== 8'h00) begin bad++; $display("FAIL carry_out got=%h exp=00", uo_out); end
    total++; if ({dut.r_z, dut.r_c} !== 2'b11) begin bad++; $display("FAIL carry_zc got=%b exp=11", {dut.r_z, dut.r_c}); end
    total++; if (uio_out !== 8'h00) begin bad++; $display("FAIL jz_pc got=%h exp=00", uio_out); end
  endtask

  task automatic test_sub();
    load('{8'h13, 8'h15, 8'h82, 8'h13, 8'h42, 8'hD0});
    do_reset(1'b1);
    for (int i = 0; i < 54; i++) tick(1'b1);
    total++; if (uo_out !== 8'hFE) begin bad++; $display("FAIL sub_out got=%h exp=FE", uo_out); end
    total++; if (dut.r_c !== 1'b0) begin bad++; $display("FAIL sub_c got=%b exp=0", dut.r_c); end
    total++; if (dut.r_reg[2] !== 8'h05) begin bad++; $display("FAIL sub_r2 got=%h exp=05", dut.r_reg[2]); end
  endtask

  task automatic test_ena_stall();
    load('{8'h15, 8'h80, 8'h13, 8'h30, 8'hD0});
    do_reset(1'b1);
    for (int c = 1; c <= 50; c++) begin
      tick(!(c >= 31 && c < 36));
      if (c == 49) begin
        total++; if (uo_out !== 8'h00) begin bad++; $display("FAIL stall_early got=%h exp=00", uo_out); end
      end
    end
    total++; if (uo_out !== 8'h08) begin bad++; $display("FAIL stall_out got=%h exp=08", uo_out); end
  endtask

  task automatic test_halt();
    int moved = 0;
    load('{8'h15, 8'hD0, 8'hF0, 8'h17, 8'hD0});
    do_reset(1'b1);
    for (int i = 0; i < 27; i++) tick(1'b1);
    total++; if (uio_out !== 8'h03) begin bad++; $display("FAIL halt_pc got=%h exp=03", uio_out); end
    for (int i = 0; i < 50; i++) begin
      tick(1'b1);
      if (uio_out !== 8'h03 || uo_out !== 8'h05) moved++;
    end
    total++; if (moved !== 0) begin bad++; $display("FAIL halt_hold got=%0d changes exp=0", moved); end
  endtask

  task automatic test_reset_mid();
    load('{8'h15, 8'h80, 8'h13, 8'h30, 8'hD0});
    do_reset(1'b1);
    for (int i = 0; i < 31; i++) tick(1'b1);
    total++; if (dut.r_phase !== 4'd4) begin bad++; $display("FAIL mid_phase got=%0d exp=4", dut.r_phase); end
    rst_n = 1'b1;
    tick(1'b1);
    total++; if ({uio_out, dut.r_acc, dut.r_reg[0], 4'(dut.r_phase)} !== 28'h0) begin
      bad++; $display("FAIL mid_reset got pc=%h acc=%h r0=%h ph=%0d exp=0", uio_out, dut.r_acc, dut.r_reg[0], dut.r_phase);
    end
    rst_n = 1'b0;
    tick(1'b1);
    total++; if (uio_out !== 8'h01 || dut.r_ir !== 8'h15) begin
      bad++; $display("FAIL mid_refetch got pc=%h ir=%h exp pc=01 ir=15", uio_out, dut.r_ir);
    end
  endtask

  task automatic test_random();
    for (int p = 0; p < 4; p++) begin
      for (int i = 0; i < 256; i++) begin
        mem[i] = 8'($urandom);
        if (mem[i][7:4] == 4'hF) mem[i][7:4] = 4'hD;
      end
      do_reset(1'($urandom));
      for (int k = 0; k < 40; k++) begin
        m_step();
        run_instr(1'b1);
        total++; if (uo_out !== m_out || uio_out !== m_pc) begin
          bad++; $display("FAIL rand_p%0d_i%0d got out=%h pc=%h exp out=%h pc=%h", p, k, uo_out, uio_out, m_out, m_pc);
        end
        total++; if (dut.r_z !== m_z || dut.r_c !== m_c || dut.r_acc !== m_acc) begin
          bad++; $display("FAIL rand_state_p%0d_i%0d got z=%b c=%b acc=%h exp z=%b c=%b acc=%h",
                          p, k, dut.r_z, dut.r_c, dut.r_acc, m_z, m_c, m_acc);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_carry_jz();
    test_sub();
    test_ena_stall();
    test_halt();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
